// File: rtl/regfile_pkg.sv
// Shared sizing defaults, helper function and basic types for the multi-port register file.
package regfile_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int XLEN_D = 32;
    localparam int NREG_D = 32;
    localparam int AW_D   = clog2(NREG_D);

    typedef logic [AW_D-1:0]   reg_addr_t;
    typedef logic [XLEN_D-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags: issue sets a flag, writeback clears it, and issue wins on a tie.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG     = NREG_D,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_addr_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    output logic [NREG-1:0]   busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_v;
    logic [NREG-1:0] clr_v;

    // A new producer supersedes the one being written back, so set dominates clear.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int r = 0; r < NREG; r++) begin
            set_v[r] = iss_en_i && (iss_addr_i == AW'(r));
            for (int p = 0; p < NWR; p++) begin
                if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == AW'(r))) begin
                    clr_v[r] = 1'b1;
                end
            end
        end
        if (ZERO_REG != 0) begin
            set_v[0] = 1'b0;
            clr_v[0] = 1'b0;
        end
        busy_d = set_v | (busy_q & ~clr_v);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_D,
    parameter int NREG     = NREG_D,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    output logic [NREG-1:0]     busy_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // Ports are scanned in ascending order so the highest-index matching port wins.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
            for (int p = 0; p < NWR; p++) begin
                if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == AW'(r))) begin
                    regs_d[r] = wr_data_i[p*XLEN +: XLEN];
                end
            end
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    regfile_scoreboard #(
        .NREG     (NREG),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .busy_o     (busy_o)
    );

    // Outputs are forced to zero while reset is held so in-flight bypass data never leaks out.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        if (!rst_i) begin
            for (int k = 0; k < NRD; k++) begin
                rd_data_o[k*XLEN +: XLEN] = regs_q[rd_addr_i[k*AW +: AW]];
                rd_busy_o[k]              = busy_o[rd_addr_i[k*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NWR; p++) begin
                        if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == rd_addr_i[k*AW +: AW])) begin
                            rd_data_o[k*XLEN +: XLEN] = wr_data_i[p*XLEN +: XLEN];
                            rd_busy_o[k]              = 1'b0;
                        end
                    end
                end
                if ((ZERO_REG != 0) && (rd_addr_i[k*AW +: AW] == '0)) begin
                    rd_data_o[k*XLEN +: XLEN] = '0;
                    rd_busy_o[k]              = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: instance a is 3R/2W with bypass, instance b is 2R/1W without bypass.
module tb_regfile_mp;

   logic clk;
   logic rst;

   logic [14:0] aRdAddr;
   logic [95:0] aRdData;
   logic [2:0]  aRdBusy;
   logic [1:0]  aWrEn;
   logic [9:0]  aWrAddr;
   logic [63:0] aWrData;
   logic        aIssEn;
   logic [4:0]  aIssAddr;
   logic [31:0] aBusy;

   logic [9:0]  bRdAddr;
   logic [63:0] bRdData;
   logic [1:0]  bRdBusy;
   logic [0:0]  bWrEn;
   logic [4:0]  bWrAddr;
   logic [31:0] bWrData;
   logic        bIssEn;
   logic [4:0]  bIssAddr;
   logic [31:0] bBusy;

   int numChecks;
   int numFailures;

   regfile_mp #(
      .XLEN(32), .NREG(32), .NRD(3), .NWR(2), .BYPASS(1), .ZERO_REG(1)
   ) dut_a (
      .clk_i(clk), .rst_i(rst),
      .rd_addr_i(aRdAddr), .rd_data_o(aRdData), .rd_busy_o(aRdBusy),
      .wr_en_i(aWrEn), .wr_addr_i(aWrAddr), .wr_data_i(aWrData),
      .iss_en_i(aIssEn), .iss_addr_i(aIssAddr), .busy_o(aBusy)
   );

   regfile_mp #(
      .XLEN(32), .NREG(32), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1)
   ) dut_b (
      .clk_i(clk), .rst_i(rst),
      .rd_addr_i(bRdAddr), .rd_data_o(bRdData), .rd_busy_o(bRdBusy),
      .wr_en_i(bWrEn), .wr_addr_i(bWrAddr), .wr_data_i(bWrData),
      .iss_en_i(bIssEn), .iss_addr_i(bIssAddr), .busy_o(bBusy)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog that ends a hung simulation and reports it as a failure.
   initial begin
      #100000;
      numFailures++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
      $finish;
   end

   task automatic reportFail(input string name, input logic [31:0] got, input logic [31:0] expVal);
      numFailures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, expVal);
   endtask

   task automatic stepClock;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [1:0] wrEn, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic issEn, input logic [4:0] issAddr);
      aWrEn    = wrEn;
      aWrAddr  = {wa1, wa0};
      aWrData  = {wd1, wd0};
      aIssEn   = issEn;
      aIssAddr = issAddr;
   endtask

   task automatic setReads(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
      aRdAddr = {r2, r1, r0};
   endtask

   task automatic clearInputs;
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
      bWrEn    = 1'b0;
      bWrAddr  = 5'd0;
      bWrData  = 32'h0;
      bIssEn   = 1'b0;
      bIssAddr = 5'd0;
   endtask

   // Main sequence: every expectation is compared directly against the DUT outputs.
   initial begin
      numChecks   = 0;
      numFailures = 0;
      rst         = 1'b1;
      aRdAddr     = '0;
      bRdAddr     = '0;
      clearInputs();
      @(negedge clk);

      applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd7);
      setReads(5'd5, 5'd0, 5'd0);
      #1;
      numChecks++; if (aRdData[31:0] !== 32'h0) reportFail("rst_hold_data", aRdData[31:0], 32'h0);
      numChecks++; if (aBusy !== 32'h0) reportFail("rst_hold_busy", aBusy, 32'h0);
      numChecks++; if (bRdData[31:0] !== 32'h0) reportFail("rst_hold_b_data", bRdData[31:0], 32'h0);
      #1;
      stepClock();
      rst = 1'b0;
      clearInputs();

      applyStimulus(2'b01, 5'd3, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0);
      setReads(5'd3, 5'd0, 5'd0);
      bWrEn = 1'b1; bWrAddr = 5'd3; bWrData = 32'h12345678;
      bRdAddr = {5'd0, 5'd3};
      #1;
      numChecks++; if (aRdData[31:0] !== 32'h12345678) reportFail("bypass_same_cycle", aRdData[31:0], 32'h12345678);
      numChecks++; if (bRdData[31:0] !== 32'h0) reportFail("nobypass_same_cycle", bRdData[31:0], 32'h0);
      #1;
      stepClock();
      clearInputs();
      #1;
      numChecks++; if (aRdData[31:0] !== 32'h12345678) reportFail("bypass_next_cycle", aRdData[31:0], 32'h12345678);
      numChecks++; if (bRdData[31:0] !== 32'h12345678) reportFail("nobypass_next_cycle", bRdData[31:0], 32'h12345678);
      #1;

      applyStimulus(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
      setReads(5'd0, 5'd0, 5'd0);
      bWrEn = 1'b1; bWrAddr = 5'd0; bWrData = 32'hFFFFFFFF;
      bRdAddr = {5'd0, 5'd0};
      #1;
      numChecks++; if (aRdData[31:0] !== 32'h0) reportFail("zero_bypass_read0", aRdData[31:0], 32'h0);
      numChecks++; if (aRdData[63:32] !== 32'h0) reportFail("zero_bypass_read1", aRdData[63:32], 32'h0);
      numChecks++; if (aRdData[95:64] !== 32'h0) reportFail("zero_bypass_read2", aRdData[95:64], 32'h0);
      numChecks++; if (aRdBusy[0] !== 1'b0) reportFail("zero_rd_busy", {31'b0, aRdBusy[0]}, 32'h0);
      #1;
      stepClock();
      clearInputs();
      #1;
      numChecks++; if (aRdData[31:0] !== 32'h0) reportFail("zero_stored_read0", aRdData[31:0], 32'h0);
      numChecks++; if (aRdData[63:32] !== 32'h0) reportFail("zero_stored_read1", aRdData[63:32], 32'h0);
      numChecks++; if (aRdData[95:64] !== 32'h0) reportFail("zero_stored_read2", aRdData[95:64], 32'h0);
      numChecks++; if (aBusy !== 32'h0) reportFail("zero_busy_vec", aBusy, 32'h0);
      numChecks++; if (bRdData[31:0] !== 32'h0) reportFail("zero_b_read", bRdData[31:0], 32'h0);
      #1;

      applyStimulus(2'b11, 5'd9, 32'h0000AAAA, 5'd9, 32'h00005555, 1'b0, 5'd0);
      setReads(5'd9, 5'd0, 5'd0);
      #1;
      numChecks++; if (aRdData[31:0] !== 32'h00005555) reportFail("conflict_bypass", aRdData[31:0], 32'h00005555);
      #1;
      stepClock();
      clearInputs();
      #1;
      numChecks++; if (aRdData[31:0] !== 32'h00005555) reportFail("conflict_stored", aRdData[31:0], 32'h00005555);
      #1;

      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4);
      setReads(5'd0, 5'd4, 5'd0);
      #1;
      numChecks++; if (aBusy !== 32'h0) reportFail("issue_same_cycle_vec", aBusy, 32'h0);
      numChecks++; if (aRdBusy[1] !== 1'b0) reportFail("issue_same_cycle_rd", {31'b0, aRdBusy[1]}, 32'h0);
      #1;
      stepClock();
      clearInputs();
      #1;
      numChecks++; if (aBusy !== 32'h00000010) reportFail("issue_busy_vec", aBusy, 32'h00000010);
      numChecks++; if (aRdBusy[1] !== 1'b1) reportFail("issue_busy_rd", {31'b0, aRdBusy[1]}, 32'h1);
      #1;
      applyStimulus(2'b01, 5'd4, 32'h0000CAFE, 5'd0, 32'h0, 1'b1, 5'd4);
      #1;
      numChecks++; if (aRdBusy[1] !== 1'b0) reportFail("wr_iss_bypass_busy", {31'b0, aRdBusy[1]}, 32'h0);
      numChecks++; if (aRdData[63:32] !== 32'h0000CAFE) reportFail("wr_iss_bypass_data", aRdData[63:32], 32'h0000CAFE);
      #1;
      stepClock();
      clearInputs();
      #1;
      numChecks++; if (aBusy !== 32'h00000010) reportFail("wr_iss_busy_vec", aBusy, 32'h00000010);
      numChecks++; if (aRdBusy[1] !== 1'b1) reportFail("wr_iss_busy_rd", {31'b0, aRdBusy[1]}, 32'h1);
      numChecks++; if (aRdData[63:32] !== 32'h0000CAFE) reportFail("wr_iss_data", aRdData[63:32], 32'h0000CAFE);
      #1;
      applyStimulus(2'b01, 5'd4, 32'h0000BEEF, 5'd0, 32'h0, 1'b0, 5'd0);
      #1;
      numChecks++; if (aRdBusy[1] !== 1'b0) reportFail("wb_bypass_busy", {31'b0, aRdBusy[1]}, 32'h0);
      #1;
      stepClock();
      clearInputs();
      #1;
      numChecks++; if (aBusy !== 32'h0) reportFail("wb_busy_vec", aBusy, 32'h0);
      numChecks++; if (aRdData[63:32] !== 32'h0000BEEF) reportFail("wb_data", aRdData[63:32], 32'h0000BEEF);
      #1;

      bIssEn = 1'b1; bIssAddr = 5'd7;
      bRdAddr = {5'd7, 5'd3};
      stepClock();
      clearInputs();
      #1;
      numChecks++; if (bBusy !== 32'h00000080) reportFail("b_issue_vec", bBusy, 32'h00000080);
      numChecks++; if (bRdBusy[1] !== 1'b1) reportFail("b_issue_rd", {31'b0, bRdBusy[1]}, 32'h1);
      #1;
      bWrEn = 1'b1; bWrAddr = 5'd7; bWrData = 32'h00000077;
      #1;
      numChecks++; if (bRdBusy[1] !== 1'b1) reportFail("b_wb_same_busy", {31'b0, bRdBusy[1]}, 32'h1);
      numChecks++; if (bRdData[63:32] !== 32'h0) reportFail("b_wb_same_data", bRdData[63:32], 32'h0);
      #1;
      stepClock();
      clearInputs();
      #1;
      numChecks++; if (bBusy !== 32'h0) reportFail("b_wb_vec", bBusy, 32'h0);
      numChecks++; if (bRdBusy[1] !== 1'b0) reportFail("b_wb_rd", {31'b0, bRdBusy[1]}, 32'h0);
      numChecks++; if (bRdData[63:32] !== 32'h00000077) reportFail("b_wb_data", bRdData[63:32], 32'h00000077);
      #1;

      applyStimulus(2'b11, 5'd1, 32'h00000011, 5'd2, 32'h00000022, 1'b0, 5'd0);
      stepClock();
      clearInputs();
      setReads(5'd1, 5'd2, 5'd1);
      #1;
      numChecks++; if (aRdData[31:0] !== 32'h00000011) reportFail("multi_rd0", aRdData[31:0], 32'h00000011);
      numChecks++; if (aRdData[63:32] !== 32'h00000022) reportFail("multi_rd1", aRdData[63:32], 32'h00000022);
      numChecks++; if (aRdData[95:64] !== 32'h00000011) reportFail("multi_rd2", aRdData[95:64], 32'h00000011);
      #1;

      applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd7);
      stepClock();
      clearInputs();
      setReads(5'd5, 5'd9, 5'd4);
      #1;
      numChecks++; if (aRdData[31:0] !== 32'hDEADBEEF) reportFail("pre_rst_data", aRdData[31:0], 32'hDEADBEEF);
      numChecks++; if (aBusy !== 32'h00000080) reportFail("pre_rst_busy", aBusy, 32'h00000080);
      numChecks++; if (aRdData[63:32] !== 32'h00005555) reportFail("pre_rst_r9", aRdData[63:32], 32'h00005555);
      #1;
      applyStimulus(2'b01, 5'd5, 32'h00001234, 5'd0, 32'h0, 1'b1, 5'd3);
      rst = 1'b1;
      #1;
      numChecks++; if (aRdData[31:0] !== 32'h0) reportFail("rst_imm_data", aRdData[31:0], 32'h0);
      numChecks++; if (aRdData[63:32] !== 32'h0) reportFail("rst_imm_r9", aRdData[63:32], 32'h0);
      numChecks++; if (aBusy !== 32'h0) reportFail("rst_imm_busy", aBusy, 32'h0);
      numChecks++; if (aRdBusy[0] !== 1'b0) reportFail("rst_imm_rd_busy", {31'b0, aRdBusy[0]}, 32'h0);
      numChecks++; if (bRdData[63:32] !== 32'h0) reportFail("rst_imm_b_data", bRdData[63:32], 32'h0);
      #1;
      stepClock();
      rst = 1'b0;
      clearInputs();
      #1;
      numChecks++; if (aRdData[31:0] !== 32'h0) reportFail("post_rst_r5", aRdData[31:0], 32'h0);
      numChecks++; if (aRdData[95:64] !== 32'h0) reportFail("post_rst_r4", aRdData[95:64], 32'h0);
      numChecks++; if (aBusy !== 32'h0) reportFail("post_rst_busy", aBusy, 32'h0);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
      $finish;
   end

endmodule
